// File: rtl/seq_divider_32_if.sv
// rtl/seq_divider_32_if.sv - start/busy/done handshake and operand/result bundle for the divider
interface seq_divider_32_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider_32.sv
// rtl/seq_divider_32.sv - restoring unsigned divider, one quotient bit per clock
module seq_divider_32 #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider_32_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;

    // The partial remainder is always < divisor, so it fits WIDTH bits; only the
    // shifted trial value t needs the extra bit for divisors >= 2^(WIDTH-1).
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   d;
    logic             borrow;
    logic [WIDTH-1:0] nxt_rem;
    logic [WIDTH-1:0] nxt_dq;

    always_comb begin
        t       = {rem, dq[WIDTH-1]};
        d       = t - {1'b0, dvs};
        borrow  = d[WIDTH];
        nxt_rem = borrow ? t[WIDTH-1:0] : d[WIDTH-1:0];
        nxt_dq  = {dq[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            dq     <= '0;
            dvs    <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            quot_q <= '0;
            rmd_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rem    <= '0;
                        dq     <= bus.dividend;
                        dvs    <= bus.divisor;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= (bus.divisor == '0) ? ZERO : RUN;
                    end
                end
                RUN: begin
                    rem   <= nxt_rem;
                    dq    <= nxt_dq;
                    count <= count + 1'b1;
                    if (count == COUNT_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        quot_q <= nxt_dq;
                        rmd_q  <= nxt_rem;
                    end
                end
                ZERO: begin
                    // dq still holds the untouched dividend
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    dbz_q  <= 1'b1;
                    quot_q <= '1;
                    rmd_q  <= dq;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmd_q;
endmodule
